// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial AES link: widths, FSM states, wire ordering.
package serial_link_pkg;

    localparam int DATA_W_DEF       = 128;
    localparam int HANDSHAKE_CYCLES = 1;
    localparam bit SEND_LSB_FIRST   = 1'b1;
    localparam bit RECV_MSB_FIRST   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HANDSHAKE,
        ST_SEND,
        ST_WAIT_TRIG_HI,
        ST_WAIT_TRIG_LO,
        ST_RECV,
        ST_FINISH
    } link_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register usable as PISO or SIPO; MSB_FIRST picks the shift direction.
module serial_shift_reg #(
    parameter int W         = 128,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] par_out
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (shift_en) begin
            data_q <= MSB_FIRST ? {data_q[W-2:0], ser_in} : {ser_in, data_q[W-1:1]};
        end
    end

    assign ser_out = MSB_FIRST ? data_q[W-1] : data_q[0];
    assign par_out = data_q;

endmodule

// File: rtl/aes_serial_host.sv
// Host-side driver for the bit-serial AES core: handshake, serial send, trigger wait,
// serial ciphertext capture, with a bounded wait on the core's trigger window.
module aes_serial_host
    import serial_link_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] ciphertext,
    output logic              s_out,
    output logic              k_out,
    input  logic              c_in,
    input  logic              trig_in
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

    link_state_t       state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic load, send_shift, recv_shift;
    logic s_ser, k_ser;
    logic              c_ser_unused;
    logic [DATA_W-1:0] s_par_unused, k_par_unused;

    serial_shift_reg #(.W(DATA_W), .MSB_FIRST(!SEND_LSB_FIRST)) u_s_sr (
        .clk(clk), .rst(rst), .load(load), .load_data(plaintext),
        .shift_en(send_shift), .ser_in(1'b0), .ser_out(s_ser), .par_out(s_par_unused)
    );

    serial_shift_reg #(.W(DATA_W), .MSB_FIRST(!SEND_LSB_FIRST)) u_k_sr (
        .clk(clk), .rst(rst), .load(load), .load_data(key),
        .shift_en(send_shift), .ser_in(1'b0), .ser_out(k_ser), .par_out(k_par_unused)
    );

    // Loading zeros here is what clears the result on an accepted start.
    serial_shift_reg #(.W(DATA_W), .MSB_FIRST(RECV_MSB_FIRST)) u_c_sr (
        .clk(clk), .rst(rst), .load(load), .load_data('0),
        .shift_en(recv_shift), .ser_in(c_in), .ser_out(c_ser_unused), .par_out(ciphertext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        load       = 1'b0;
        send_shift = 1'b0;
        recv_shift = 1'b0;
        done       = 1'b0;
        s_out      = 1'b0;
        k_out      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = ST_HANDSHAKE;
                end
            end
            ST_HANDSHAKE: begin
                s_out   = 1'b1;
                k_out   = 1'b1;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                s_out      = s_ser;
                k_out      = k_ser;
                send_shift = 1'b1;
                if (idx_q == CNT_W'(DATA_W - 1)) begin
                    wait_d  = '0;
                    state_d = ST_WAIT_TRIG_HI;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_WAIT_TRIG_HI: begin
                if (trig_in) begin
                    wait_d  = '0;
                    state_d = ST_WAIT_TRIG_LO;
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WAIT_TRIG_LO: begin
                // The falling-edge sample already carries the ciphertext MSB.
                if (!trig_in) begin
                    recv_shift = 1'b1;
                    idx_d      = CNT_W'(DATA_W - 2);
                    state_d    = ST_RECV;
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RECV: begin
                recv_shift = 1'b1;
                if (idx_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d = idx_q - CNT_W'(1);
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_aes_serial_host.sv
// Bench for aes_serial_host: behavioural serial AES core responder plus a done-driven scoreboard.
module tb_aes_serial_host;

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         busy, done, timeout, s_out, k_out;
    logic [127:0] ciphertext;
    logic         c_in = 1'b0;
    logic         trig_in = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [128:0] exp_q[$];
    logic resp_en = 1'b1;

    aes_serial_host #(.DATA_W(128), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .key(key),
        .busy(busy), .done(done), .timeout(timeout), .ciphertext(ciphertext),
        .s_out(s_out), .k_out(k_out), .c_in(c_in), .trig_in(trig_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Known-answer core: FIPS-197 vectors, otherwise pt^key so the send path is still verified.
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == PT_C && k == KEY_C) return CT_C;
        if (p == PT_B && k == KEY_B) return CT_B;
        return p ^ k;
    endfunction

    // Responder steps 1 time unit after each rising edge.
    typedef enum {R_IDLE, R_RX, R_DLY, R_HI, R_TX, R_END} rstate_t;
    initial begin
        rstate_t rs;
        int n;
        logic [127:0] rx_pt, rx_key, rsp_ct;
        rs = R_IDLE; n = 0; rx_pt = '0; rx_key = '0; rsp_ct = '0;
        forever begin
            @(posedge clk); #1;
            if (rst || !resp_en) begin
                rs = R_IDLE; trig_in = 1'b0; c_in = 1'b0;
            end else begin
                case (rs)
                    R_IDLE: if (s_out && k_out) begin rs = R_RX; n = 0; end
                    R_RX: begin
                        rx_pt[n] = s_out; rx_key[n] = k_out;
                        if (n == 127) begin rs = R_DLY; n = 0; end else n++;
                    end
                    R_DLY: if (n == 4) begin rs = R_HI; n = 0; trig_in = 1'b1; end else n++;
                    R_HI: if (n == 7) begin
                        trig_in = 1'b0;
                        rsp_ct = core_fn(rx_pt, rx_key);
                        c_in = rsp_ct[127];
                        n = 126; rs = R_TX;
                    end else n++;
                    R_TX: begin
                        c_in = rsp_ct[n];
                        if (n == 0) rs = R_END; else n--;
                    end
                    R_END: begin c_in = 1'b0; rs = R_IDLE; end
                    default: rs = R_IDLE;
                endcase
            end
        end
    end

    // Scoreboard monitor: every done pulse consumes one expected {timeout, ciphertext}.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 128'(done), 128'(0));
            end else begin
                logic [128:0] e;
                e = exp_q.pop_front();
                chk("ciphertext", ciphertext, e[127:0]);
                chk("timeout_flag", 128'(timeout), 128'(e[128]));
            end
        end
    end

    task automatic do_start(input logic [127:0] p, input logic [127:0] k);
        @(negedge clk);
        plaintext = p; key = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        if (!done) chk("done_wait_expired", 128'(done), 128'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        chk("rst_timeout", 128'(timeout), 0);
        chk("rst_lines", {126'b0, s_out, k_out}, 0);
        chk("rst_ciphertext", ciphertext, 0);

        // FIPS-197 known answer
        exp_q.push_back({1'b0, CT_C});
        do_start(PT_C, KEY_C);
        wait_done();

        // Wire-level ordering; now at cycle +1
        exp_q.push_back({1'b0, 128'h1 ^ {1'b1, 127'b0}});
        do_start(128'h1, {1'b1, 127'b0});
        for (int c = 1; c <= 140; c++) begin
            chk($sformatf("s_out_c%0d", c), 128'(s_out), 128'(c == 1 || c == 2));
            chk($sformatf("k_out_c%0d", c), 128'(k_out), 128'(c == 1 || c == 129));
            @(negedge clk);
        end
        wait_done();

        // start during SEND must be ignored
        exp_q.push_back({1'b0, CT_B});
        do_start(PT_B, KEY_B);
        repeat (40) @(negedge clk);
        plaintext = PT_C; key = KEY_C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset at SEND bit 60 (cycle +62)
        do_start(PT_B, KEY_B);
        repeat (61) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 128'(busy), 0);
        chk("midrst_done", 128'(done), 0);
        chk("midrst_lines", {126'b0, s_out, k_out}, 0);
        chk("midrst_ciphertext", ciphertext, 0);
        rst = 1'b0;
        exp_q.push_back({1'b0, CT_C});
        do_start(PT_C, KEY_C);
        wait_done();

        // Trigger never arrives: FINISH 16 cycles after WAIT_TRIG_HI entry (+130)
        resp_en = 1'b0;
        exp_q.push_back({1'b1, 128'b0});
        do_start(PT_B, KEY_B);
        begin
            int c = 1;
            while (!done && c < 400) begin @(negedge clk); c++; end
            chk("timeout_latency", 128'(c), 128'(146));
        end
        @(negedge clk);
        resp_en = 1'b1;

        // Back-to-back: second start in the IDLE cycle after FINISH
        exp_q.push_back({1'b0, CT_B});
        exp_q.push_back({1'b0, CT_C});
        do_start(PT_B, KEY_B);
        wait_done();
        @(negedge clk);
        chk("b2b_idle_gap", 128'(busy), 0);
        plaintext = PT_C; key = KEY_C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_again", 128'(busy), 1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("pending_expected", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
